// File: rtl/titan_core_router.sv
// Routes one instruction_handler transaction to one of NUM_CORES core slots by address window.
// Optional statistics counters are enabled with `define TITAN_ROUTER_STATS_EN.
module titan_core_router #(
  parameter int          NUM_CORES      = 4,
  parameter int          WINDOW_BITS    = 4,
  parameter int          BASE_ADDRESS   = 0,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RESULT     = 32'hFFFF_FFFF
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [7:0]              instruction_i,
  input  logic [23:0]             address_i,
  input  logic [31:0]             value_i,
  output logic [NUM_CORES-1:0]    core_sel_o,
  output logic [7:0]              core_instr_o,
  output logic [23:0]             core_addr_o,
  output logic [31:0]             core_value_o,
  input  logic [NUM_CORES-1:0]    core_ack_i,
  input  logic [32*NUM_CORES-1:0] core_result_i,
  output logic                    resp_valid_o,
  output logic [31:0]             result_o,
`ifdef TITAN_ROUTER_STATS_EN
  output logic [15:0]             stat_ok_o,
  output logic [15:0]             stat_err_o,
`endif
  output logic                    resp_err_o
);

  localparam int          IW       = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int          CW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [23:0] BASE     = 24'(BASE_ADDRESS);
  localparam logic [23:0] OFF_MASK = 24'((1 << WINDOW_BITS) - 1);
  localparam logic [CW-1:0] LAST   = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t         state;
  logic [IW-1:0]  idx;
  logic [CW-1:0]  cnt;
  logic [7:0]     instr;
  logic [23:0]    offset;
  logic [31:0]    value;
  logic [31:0]    result;
  logic           err;
  logic           resp_valid;
  logic           ready;
  logic [NUM_CORES-1:0] sel;

  // A 25-bit subtraction keeps addresses below the base from wrapping into a valid window.
  logic [24:0]    diff;
  logic [23:0]    slot;
  logic           hit;
  logic [IW-1:0]  slot_idx;
  logic           ack_sel;
  logic [31:0]    ack_result;

  assign diff       = {1'b0, address_i} - {1'b0, BASE};
  assign slot       = diff[23:0] >> WINDOW_BITS;
  assign hit        = !diff[24] && (slot < 24'(NUM_CORES));
  assign slot_idx   = slot[IW-1:0];
  assign ack_sel    = core_ack_i[idx];
  assign ack_result = core_result_i[32*idx +: 32];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      idx        <= '0;
      cnt        <= '0;
      instr      <= '0;
      offset     <= '0;
      value      <= '0;
      result     <= '0;
      err        <= 1'b0;
      resp_valid <= 1'b0;
      ready      <= 1'b1;
      sel        <= '0;
    end else begin
      sel        <= '0;
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid_i && ready) begin
            instr <= instruction_i;
            value <= value_i;
            ready <= 1'b0;
            if (hit) begin
              idx    <= slot_idx;
              offset <= diff[23:0] & OFF_MASK;
              sel    <= NUM_CORES'(1) << slot_idx;
              state  <= ISSUE;
            end else begin
              result     <= ERR_RESULT;
              err        <= 1'b1;
              resp_valid <= 1'b1;
              state      <= RESP;
            end
          end
        end
        ISSUE: begin
          cnt <= '0;
          if (ack_sel) begin
            result     <= ack_result;
            err        <= 1'b0;
            resp_valid <= 1'b1;
            state      <= RESP;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          // An ack arriving on the final counted cycle still beats the timeout.
          if (ack_sel) begin
            result     <= ack_result;
            err        <= 1'b0;
            resp_valid <= 1'b1;
            state      <= RESP;
          end else if (cnt == LAST) begin
            result     <= ERR_RESULT;
            err        <= 1'b1;
            resp_valid <= 1'b1;
            state      <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          ready <= 1'b1;
          state <= IDLE;
        end
        default: begin
          ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

  assign req_ready_o  = ready;
  assign core_sel_o   = sel;
  assign core_instr_o = instr;
  assign core_addr_o  = offset;
  assign core_value_o = value;
  assign resp_valid_o = resp_valid;
  assign result_o     = result;
  assign resp_err_o   = err;

`ifdef TITAN_ROUTER_STATS_EN
  logic [15:0] stat_ok;
  logic [15:0] stat_err;

  // Saturating response counters, split by the error flag of each response.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stat_ok  <= '0;
      stat_err <= '0;
    end else if (resp_valid) begin
      if (err) begin
        if (stat_err != 16'hFFFF) stat_err <= stat_err + 16'd1;
      end else begin
        if (stat_ok != 16'hFFFF) stat_ok <= stat_ok + 16'd1;
      end
    end
  end

  assign stat_ok_o  = stat_ok;
  assign stat_err_o = stat_err;
`endif

endmodule
